// File: rtl/life_fifo_gen2.sv
// -----------------------------------------------------------------------------
// life_fifo_gen2
//   Queue of {value, life} entries placed between spike generators and neuron
//   update units. Every accepted dequeue emits the head entry with its life
//   reduced by one. The RECIRC parameter selects what happens to a head entry
//   that still has life left after the dequeue:
//     RECIRC = 0 : the head stays in place and its stored life is decremented.
//     RECIRC = 1 : the head is popped and written back at the tail with the
//                  decremented life, which gives round-robin spike replay.
//   An entry whose life reaches 0 on a dequeue is popped in either mode.
//
// Parameters
//   VAL_W     payload width
//   LIFE_W    life counter width
//   ADDR_LEN  log2 of the queue depth
//   RECIRC    0 = hold at head, 1 = recirculate to tail
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active low (0 = reset)
//   enq        enqueue request, with val_in / life_in
//   deq        dequeue request
//   val_out    payload of the last accepted dequeue (registered)
//   life_out   life-1 of the last accepted dequeue (registered)
//   out_valid  high for one cycle after an accepted dequeue
//   full       count == DEPTH (from the registered count only)
//   empty      count == 0     (from the registered count only)
//   count      number of stored entries
//   drop       high for one cycle after a rejected enqueue
// -----------------------------------------------------------------------------
module life_fifo_gen2 #(
    parameter int VAL_W    = 16,
    parameter int LIFE_W   = 16,
    parameter int ADDR_LEN = 2,
    parameter int RECIRC   = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enq,
    input  logic                deq,
    input  logic [VAL_W-1:0]    val_in,
    input  logic [LIFE_W-1:0]   life_in,
    output logic [VAL_W-1:0]    val_out,
    output logic [LIFE_W-1:0]   life_out,
    output logic                out_valid,
    output logic                full,
    output logic                empty,
    output logic [ADDR_LEN:0]   count,
    output logic                drop
);

    localparam int DEPTH = 1 << ADDR_LEN;
    localparam logic [ADDR_LEN:0] DEPTH_CNT = (ADDR_LEN + 1)'(DEPTH);

    // Entry storage. The head entry must be known in the same cycle as the
    // dequeue request (pop decision and in-place decrement), so it is read
    // asynchronously; at these depths this maps to distributed RAM.
    logic [VAL_W-1:0]  val_mem  [DEPTH];
    logic [LIFE_W-1:0] life_mem [DEPTH];

    logic [ADDR_LEN-1:0] head_reg, head_next;
    logic [ADDR_LEN-1:0] tail_reg, tail_next;
    logic [ADDR_LEN:0]   count_reg, count_next;
    logic [VAL_W-1:0]    val_out_reg;
    logic [LIFE_W-1:0]   life_out_reg;
    logic                out_valid_reg;
    logic                drop_reg;

    logic                deq_ok;
    logic                final_pop;
    logic                recirc_wr;
    logic                hold_dec;
    logic                enq_ok;
    logic [VAL_W-1:0]    head_val;
    logic [LIFE_W-1:0]   head_life_dec;
    logic [ADDR_LEN-1:0] enq_addr;

    always_comb begin
        head_val      = val_mem[head_reg];
        // A stored life is never 0, so this cannot wrap for a real entry.
        head_life_dec = life_mem[head_reg] - LIFE_W'(1);

        deq_ok    = deq && (count_reg != '0);
        final_pop = deq_ok && (head_life_dec == '0);
        recirc_wr = deq_ok && !final_pop && (RECIRC != 0);
        hold_dec  = deq_ok && !final_pop && (RECIRC == 0);

        // A final-life pop frees a slot in the same cycle, so a full queue
        // can still take a new entry. A recirculating dequeue frees nothing.
        enq_ok = enq && (life_in != '0) && ((count_reg != DEPTH_CNT) || final_pop);

        // The recirculated head claims the current tail slot first, so the
        // new entry lands one slot behind it.
        enq_addr = recirc_wr ? (tail_reg + ADDR_LEN'(1)) : tail_reg;

        head_next  = head_reg + ADDR_LEN'(final_pop || recirc_wr);
        tail_next  = tail_reg + ADDR_LEN'(recirc_wr) + ADDR_LEN'(enq_ok);
        count_next = count_reg + (ADDR_LEN + 1)'(enq_ok) - (ADDR_LEN + 1)'(final_pop);
    end

    // Storage writes. Contents are deliberately left alone by reset; the
    // pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (hold_dec) begin
                life_mem[head_reg] <= head_life_dec;
            end
            if (recirc_wr) begin
                val_mem[tail_reg]  <= head_val;
                life_mem[tail_reg] <= head_life_dec;
            end
            if (enq_ok) begin
                val_mem[enq_addr]  <= val_in;
                life_mem[enq_addr] <= life_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_reg      <= '0;
            tail_reg      <= '0;
            count_reg     <= '0;
            val_out_reg   <= '0;
            life_out_reg  <= '0;
            out_valid_reg <= 1'b0;
            drop_reg      <= 1'b0;
        end else begin
            head_reg      <= head_next;
            tail_reg      <= tail_next;
            count_reg     <= count_next;
            out_valid_reg <= deq_ok;
            drop_reg      <= enq && !enq_ok;
            // Output data holds its last value when no dequeue is accepted.
            if (deq_ok) begin
                val_out_reg  <= head_val;
                life_out_reg <= head_life_dec;
            end
        end
    end

    assign val_out   = val_out_reg;
    assign life_out  = life_out_reg;
    assign out_valid = out_valid_reg;
    assign drop      = drop_reg;
    assign count     = count_reg;
    assign full      = (count_reg == DEPTH_CNT);
    assign empty     = (count_reg == '0);

endmodule

// File: tb/tb_life_fifo_gen2.sv
module tb_life_fifo_gen2;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        enq;
    logic        deq;
    logic [15:0] val_in;
    logic [15:0] life_in;

    // Index 0: hold-at-head instance, index 1: recirculating instance.
    logic [15:0] val_out_w   [2];
    logic [15:0] life_out_w  [2];
    logic        out_valid_w [2];
    logic        full_w      [2];
    logic        empty_w     [2];
    logic [2:0]  count_w     [2];
    logic        drop_w      [2];

    int tests_run = 0;
    int tests_failed = 0;

    life_fifo_gen2 #(.VAL_W(16), .LIFE_W(16), .ADDR_LEN(2), .RECIRC(0)) dut0 (
        .clk(clk), .rst(rst), .enq(enq), .deq(deq),
        .val_in(val_in), .life_in(life_in),
        .val_out(val_out_w[0]), .life_out(life_out_w[0]), .out_valid(out_valid_w[0]),
        .full(full_w[0]), .empty(empty_w[0]), .count(count_w[0]), .drop(drop_w[0])
    );

    life_fifo_gen2 #(.VAL_W(16), .LIFE_W(16), .ADDR_LEN(2), .RECIRC(1)) dut1 (
        .clk(clk), .rst(rst), .enq(enq), .deq(deq),
        .val_in(val_in), .life_in(life_in),
        .val_out(val_out_w[1]), .life_out(life_out_w[1]), .out_valid(out_valid_w[1]),
        .full(full_w[1]), .empty(empty_w[1]), .count(count_w[1]), .drop(drop_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: an ordered list per instance, element 0 is the head.
    // ------------------------------------------------------------------
    logic [15:0] mv    [2][DEPTH];
    logic [15:0] ml    [2][DEPTH];
    int          msz   [2];
    logic [15:0] m_ov  [2];
    logic [15:0] m_ol  [2];
    bit          m_vld [2];
    bit          m_drp [2];

    task automatic model_pop_head(input int m);
        for (int i = 0; i < DEPTH - 1; i++) begin
            mv[m][i] = mv[m][i+1];
            ml[m][i] = ml[m][i+1];
        end
        msz[m]--;
    endtask

    task automatic model_append(input int m, input logic [15:0] v, input logic [15:0] l);
        mv[m][msz[m]] = v;
        ml[m][msz[m]] = l;
        msz[m]++;
    endtask

    task automatic model_step(input bit r, input bit e, input bit d,
                              input logic [15:0] v, input logic [15:0] l);
        logic [15:0] hv, hl;
        for (int m = 0; m < 2; m++) begin
            if (r) begin
                msz[m] = 0; m_ov[m] = 0; m_ol[m] = 0; m_vld[m] = 0; m_drp[m] = 0;
            end else begin
                m_vld[m] = 0;
                m_drp[m] = 0;
                if (d && msz[m] > 0) begin
                    hv = mv[m][0];
                    hl = ml[m][0];
                    m_ov[m] = hv;
                    m_ol[m] = hl - 16'd1;
                    m_vld[m] = 1;
                    if (hl == 16'd1) begin
                        model_pop_head(m);
                    end else if (m == 0) begin
                        ml[m][0] = hl - 16'd1;
                    end else begin
                        model_pop_head(m);
                        model_append(m, hv, hl - 16'd1);
                    end
                end
                // Space is judged after the dequeue has been applied.
                if (e) begin
                    if (l != 0 && msz[m] < DEPTH) model_append(m, v, l);
                    else m_drp[m] = 1;
                end
            end
        end
    endtask

    task automatic check(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s dut%0d: got %0h, want %0h (t=%0t)", name, m, act, exp, $time);
        end
    endtask

    task automatic check_model;
        for (int m = 0; m < 2; m++) begin
            check("val_out",   m, 32'(val_out_w[m]),   32'(m_ov[m]));
            check("life_out",  m, 32'(life_out_w[m]),  32'(m_ol[m]));
            check("out_valid", m, 32'(out_valid_w[m]), 32'(m_vld[m]));
            check("drop",      m, 32'(drop_w[m]),      32'(m_drp[m]));
            check("count",     m, 32'(count_w[m]),     32'(msz[m]));
            check("full",      m, 32'(full_w[m]),      32'(msz[m] == DEPTH));
            check("empty",     m, 32'(empty_w[m]),     32'(msz[m] == 0));
        end
    endtask

    // One clock: drive, edge, settle, advance model, compare both instances.
    task automatic step(input bit r, input bit e, input bit d,
                        input logic [15:0] v, input logic [15:0] l);
        rst = r ? 1'b0 : 1'b1;
        enq = e; deq = d; val_in = v; life_in = l;
        @(posedge clk);
        #1;
        model_step(r, e, d, v, l);
        check_model();
        $display("[TB] t=%0t rst=%0b enq=%0b deq=%0b in=(%0d,%0d) | d0 v=%0b out=(%0d,%0d) c=%0d drop=%0b | d1 v=%0b out=(%0d,%0d) c=%0d drop=%0b",
                 $time, r, e, d, v, l,
                 out_valid_w[0], val_out_w[0], life_out_w[0], count_w[0], drop_w[0],
                 out_valid_w[1], val_out_w[1], life_out_w[1], count_w[1], drop_w[1]);
    endtask

    // ------------------------------------------------------------------
    // Directed vectors: expectations written from the behavioural rules.
    // ------------------------------------------------------------------
    typedef struct {
        int          sel;
        bit          rs;
        bit          e;
        bit          d;
        logic [15:0] v;
        logic [15:0] l;
        bit          x_valid;
        logic [15:0] x_val;
        logic [15:0] x_life;
        int          x_count;
        bit          x_drop;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(int sel, bit rs, bit e, bit d, int v, int l,
                                bit xv, int xval, int xlife, int xc, bit xd);
        vec_t t;
        t.sel = sel; t.rs = rs; t.e = e; t.d = d; t.v = 16'(v); t.l = 16'(l);
        t.x_valid = xv; t.x_val = 16'(xval); t.x_life = 16'(xlife);
        t.x_count = xc; t.x_drop = xd;
        vecs.push_back(t);
    endfunction

    initial begin
        rst = 1'b0; enq = 0; deq = 0; val_in = 0; life_in = 0;

        //   sel rs e d  val life   valid val life count drop
        // Hold mode sequence, then rejects
        add(0, 1, 0, 0,   0, 0,     0,   0, 0,   0,   0);
        add(0, 0, 1, 0,  42, 3,     0,   0, 0,   1,   0);
        add(0, 0, 1, 0,  27, 1,     0,   0, 0,   2,   0);
        add(0, 0, 0, 1,   0, 0,     1,  42, 2,   2,   0);
        add(0, 0, 0, 1,   0, 0,     1,  42, 1,   2,   0);
        add(0, 0, 0, 1,   0, 0,     1,  42, 0,   1,   0);
        add(0, 0, 0, 1,   0, 0,     1,  27, 0,   0,   0);
        add(0, 0, 0, 1,   0, 0,     0,  27, 0,   0,   0);   // deq on empty holds
        add(0, 0, 1, 0,   8, 0,     0,  27, 0,   0,   1);   // zero life rejected
        // Recirculating sequence
        add(1, 1, 0, 0,   0, 0,     0,   0, 0,   0,   0);
        add(1, 0, 1, 0,   5, 2,     0,   0, 0,   1,   0);
        add(1, 0, 1, 0,   6, 1,     0,   0, 0,   2,   0);
        add(1, 0, 1, 0,   7, 2,     0,   0, 0,   3,   0);
        add(1, 0, 0, 1,   0, 0,     1,   5, 1,   3,   0);
        add(1, 0, 0, 1,   0, 0,     1,   6, 0,   2,   0);
        add(1, 0, 0, 1,   0, 0,     1,   7, 1,   2,   0);
        add(1, 0, 0, 1,   0, 0,     1,   5, 0,   1,   0);
        add(1, 0, 0, 1,   0, 0,     1,   7, 0,   0,   0);
        // Full boundary (hold mode)
        add(0, 1, 0, 0,   0, 0,     0,   0, 0,   0,   0);
        add(0, 0, 1, 0,   1, 1,     0,   0, 0,   1,   0);
        add(0, 0, 1, 0,   2, 1,     0,   0, 0,   2,   0);
        add(0, 0, 1, 0,   3, 1,     0,   0, 0,   3,   0);
        add(0, 0, 1, 0,   4, 1,     0,   0, 0,   4,   0);
        add(0, 0, 1, 0,   9, 1,     0,   0, 0,   4,   1);
        add(0, 0, 1, 1,   9, 1,     1,   1, 0,   4,   0);
        add(0, 0, 1, 0,   8, 0,     0,   1, 0,   4,   1);

        foreach (vecs[i]) begin
            step(vecs[i].rs, vecs[i].e, vecs[i].d, vecs[i].v, vecs[i].l);
            check($sformatf("vec%0d.valid", i), vecs[i].sel, 32'(out_valid_w[vecs[i].sel]), 32'(vecs[i].x_valid));
            check($sformatf("vec%0d.val",   i), vecs[i].sel, 32'(val_out_w[vecs[i].sel]),   32'(vecs[i].x_val));
            check($sformatf("vec%0d.life",  i), vecs[i].sel, 32'(life_out_w[vecs[i].sel]),  32'(vecs[i].x_life));
            check($sformatf("vec%0d.count", i), vecs[i].sel, 32'(count_w[vecs[i].sel]),     32'(vecs[i].x_count));
            check($sformatf("vec%0d.drop",  i), vecs[i].sel, 32'(drop_w[vecs[i].sel]),      32'(vecs[i].x_drop));
        end

        // Wrap: one preload, then back-to-back enq+deq pairs in FIFO order.
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 100, 1);
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 1, 16'(200 + i), 1);
            for (int m = 0; m < 2; m++) begin
                check("wrap.valid", m, 32'(out_valid_w[m]), 32'd1);
                check("wrap.val",   m, 32'(val_out_w[m]),   (i == 0) ? 32'd100 : 32'(200 + i - 1));
                check("wrap.life",  m, 32'(life_out_w[m]),  32'd0);
                check("wrap.count", m, 32'(count_w[m]),     32'd1);
                check("wrap.drop",  m, 32'(drop_w[m]),      32'd0);
            end
        end

        // Reset in the middle of operation.
        step(0, 1, 0, 1, 2);
        step(0, 1, 0, 2, 2);
        check("mid.count_pre", 0, 32'(count_w[0]), 32'd3);
        step(1, 0, 0, 0, 0);
        for (int m = 0; m < 2; m++) begin
            check("mid.count", m, 32'(count_w[m]),     32'd0);
            check("mid.empty", m, 32'(empty_w[m]),     32'd1);
            check("mid.valid", m, 32'(out_valid_w[m]), 32'd0);
        end
        step(0, 1, 0, 11, 1);
        step(0, 0, 1, 0, 0);
        for (int m = 0; m < 2; m++) begin
            check("mid.out_val",  m, 32'(val_out_w[m]),  32'd11);
            check("mid.out_life", m, 32'(life_out_w[m]), 32'd0);
            check("mid.out_vld",  m, 32'(out_valid_w[m]), 32'd1);
        end

        // Randomised traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            bit r, e, d;
            logic [15:0] v, l;
            r = ($urandom_range(0, 99) == 0);
            e = ($urandom_range(0, 99) < 55);
            d = ($urandom_range(0, 99) < 50);
            v = 16'($urandom);
            l = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 4));
            step(r, e, d, v, l);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
